// File: rtl/rs_issue_queue.sv
// ALU reservation station: 16 entries, B/L bus snooping, one registered issue per cycle.
// Optional RS_WAKEUP_BYPASS_EN lets an entry woken by this cycle's broadcast issue at the same edge.
module rs_issue_queue #(
    parameter int RS_LOG  = 4,
    parameter int OP_LOG  = 6,
    parameter int ROB_LOG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               clr,
    input  logic               D_valid,
    input  logic [OP_LOG-1:0]  D_op,
    input  logic               D_Qj_busy,
    input  logic [ROB_LOG-1:0] D_Qj,
    input  logic [31:0]        D_Vj,
    input  logic               D_Qk_busy,
    input  logic [ROB_LOG-1:0] D_Qk,
    input  logic [31:0]        D_Vk,
    input  logic [31:0]        D_Imm,
    input  logic [ROB_LOG-1:0] D_DestRob,
    input  logic [31:0]        D_CurPC,
    output logic               full,
    input  logic               B_enable,
    input  logic [ROB_LOG-1:0] B_RobId,
    input  logic [31:0]        B_value,
    input  logic               L_enable,
    input  logic [ROB_LOG-1:0] L_RobId,
    input  logic [31:0]        L_value,
    output logic               RS_valid,
    output logic [OP_LOG-1:0]  RS_op,
    output logic [31:0]        RS_Vj,
    output logic [31:0]        RS_Vk,
    output logic [31:0]        RS_Imm,
    output logic [ROB_LOG-1:0] RS_DestRob,
    output logic [31:0]        RS_CurPC
);

    localparam int RS_SIZE = 1 << RS_LOG;
    localparam logic [OP_LOG-1:0] OP_NOP = {OP_LOG{1'b0}};

    logic [RS_SIZE-1:0] busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
    logic [OP_LOG-1:0]  op_q   [RS_SIZE];
    logic [OP_LOG-1:0]  op_d   [RS_SIZE];
    logic [31:0]        vj_q   [RS_SIZE];
    logic [31:0]        vj_d   [RS_SIZE];
    logic [31:0]        vk_q   [RS_SIZE];
    logic [31:0]        vk_d   [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [31:0]        imm_d  [RS_SIZE];
    logic [31:0]        pc_q   [RS_SIZE];
    logic [31:0]        pc_d   [RS_SIZE];
    logic [ROB_LOG-1:0] qj_q   [RS_SIZE];
    logic [ROB_LOG-1:0] qj_d   [RS_SIZE];
    logic [ROB_LOG-1:0] qk_q   [RS_SIZE];
    logic [ROB_LOG-1:0] qk_d   [RS_SIZE];
    logic [ROB_LOG-1:0] dest_q [RS_SIZE];
    logic [ROB_LOG-1:0] dest_d [RS_SIZE];

    logic               rs_valid_q, rs_valid_d;
    logic [OP_LOG-1:0]  rs_op_q, rs_op_d;
    logic [31:0]        rs_vj_q, rs_vj_d, rs_vk_q, rs_vk_d;
    logic [31:0]        rs_imm_q, rs_imm_d, rs_pc_q, rs_pc_d;
    logic [ROB_LOG-1:0] rs_dest_q, rs_dest_d;

    logic [RS_SIZE-1:0] b_hit_j_s, l_hit_j_s, b_hit_k_s, l_hit_k_s;
    logic [RS_SIZE-1:0] rj_eff_s, rk_eff_s;
    logic [31:0]        fwd_vj_s [RS_SIZE];
    logic [31:0]        fwd_vk_s [RS_SIZE];
    logic               sel_found_s, free_found_s, full_s;
    logic [RS_LOG-1:0]  sel_idx_s, free_idx_s;
    logic [32:0]        disp_j_s, disp_k_s;

    // Returns {ready, value} for an operand arriving at dispatch; B beats L.
    function automatic logic [32:0] dispatch_operand(
        input logic               pend,
        input logic [ROB_LOG-1:0] tag,
        input logic [31:0]        val,
        input logic               b_en,
        input logic [ROB_LOG-1:0] b_tag,
        input logic [31:0]        b_val,
        input logic               l_en,
        input logic [ROB_LOG-1:0] l_tag,
        input logic [31:0]        l_val
    );
        logic [32:0] res;
        if (!pend) begin
            res = {1'b1, val};
        end else if (b_en && (tag == b_tag)) begin
            res = {1'b1, b_val};
        end else if (l_en && (tag == l_tag)) begin
            res = {1'b1, l_val};
        end else begin
            res = {1'b0, val};
        end
        return res;
    endfunction

    assign full_s = &busy_q;
    assign full   = full_s;

    // Per-entry tag matches against both buses and the effective ready view used by select.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            b_hit_j_s[i] = B_enable & (qj_q[i] == B_RobId);
            l_hit_j_s[i] = L_enable & (qj_q[i] == L_RobId);
            b_hit_k_s[i] = B_enable & (qk_q[i] == B_RobId);
            l_hit_k_s[i] = L_enable & (qk_q[i] == L_RobId);
`ifdef RS_WAKEUP_BYPASS_EN
            rj_eff_s[i] = rj_q[i] | b_hit_j_s[i] | l_hit_j_s[i];
            rk_eff_s[i] = rk_q[i] | b_hit_k_s[i] | l_hit_k_s[i];
            fwd_vj_s[i] = rj_q[i] ? vj_q[i] : (b_hit_j_s[i] ? B_value : L_value);
            fwd_vk_s[i] = rk_q[i] ? vk_q[i] : (b_hit_k_s[i] ? B_value : L_value);
`else
            rj_eff_s[i] = rj_q[i];
            rk_eff_s[i] = rk_q[i];
            fwd_vj_s[i] = vj_q[i];
            fwd_vk_s[i] = vk_q[i];
`endif
        end
    end

    // Lowest-index ready entry for issue and lowest-index free entry for dispatch.
    always_comb begin
        sel_found_s  = 1'b0;
        sel_idx_s    = {RS_LOG{1'b0}};
        free_found_s = 1'b0;
        free_idx_s   = {RS_LOG{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy_q[i] && rj_eff_s[i] && rk_eff_s[i]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = RS_LOG'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
            if (!busy_q[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = RS_LOG'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
        disp_j_s = dispatch_operand(D_Qj_busy, D_Qj, D_Vj, B_enable, B_RobId, B_value,
                                    L_enable, L_RobId, L_value);
        disp_k_s = dispatch_operand(D_Qk_busy, D_Qk, D_Vk, B_enable, B_RobId, B_value,
                                    L_enable, L_RobId, L_value);
    end

    // Next state: flush, or snoop + issue + dispatch. A slot freed by issue is not
    // reused this edge because the free search only looks at registered busy bits.
    always_comb begin
        busy_d = busy_q;
        rj_d   = rj_q;
        rk_d   = rk_q;
        op_d   = op_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        dest_d = dest_q;
        rs_valid_d = rs_valid_q;
        rs_op_d    = rs_op_q;
        rs_vj_d    = rs_vj_q;
        rs_vk_d    = rs_vk_q;
        rs_imm_d   = rs_imm_q;
        rs_pc_d    = rs_pc_q;
        rs_dest_d  = rs_dest_q;
        if (clr) begin
            busy_d     = {RS_SIZE{1'b0}};
            rs_valid_d = 1'b0;
            rs_op_d    = OP_NOP;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && !rj_q[i] && (b_hit_j_s[i] || l_hit_j_s[i])) begin
                    rj_d[i] = 1'b1;
                    vj_d[i] = b_hit_j_s[i] ? B_value : L_value;
                end else begin
                    rj_d[i] = rj_d[i];
                end
                if (busy_q[i] && !rk_q[i] && (b_hit_k_s[i] || l_hit_k_s[i])) begin
                    rk_d[i] = 1'b1;
                    vk_d[i] = b_hit_k_s[i] ? B_value : L_value;
                end else begin
                    rk_d[i] = rk_d[i];
                end
            end
            if (sel_found_s) begin
                busy_d[sel_idx_s] = 1'b0;
                rs_valid_d = 1'b1;
                rs_op_d    = op_q[sel_idx_s];
                rs_vj_d    = fwd_vj_s[sel_idx_s];
                rs_vk_d    = fwd_vk_s[sel_idx_s];
                rs_imm_d   = imm_q[sel_idx_s];
                rs_pc_d    = pc_q[sel_idx_s];
                rs_dest_d  = dest_q[sel_idx_s];
            end else begin
                rs_valid_d = 1'b0;
                rs_op_d    = OP_NOP;
            end
            if (D_valid && !full_s && free_found_s) begin
                busy_d[free_idx_s] = 1'b1;
                op_d[free_idx_s]   = D_op;
                qj_d[free_idx_s]   = D_Qj;
                qk_d[free_idx_s]   = D_Qk;
                rj_d[free_idx_s]   = disp_j_s[32];
                vj_d[free_idx_s]   = disp_j_s[31:0];
                rk_d[free_idx_s]   = disp_k_s[32];
                vk_d[free_idx_s]   = disp_k_s[31:0];
                imm_d[free_idx_s]  = D_Imm;
                pc_d[free_idx_s]   = D_CurPC;
                dest_d[free_idx_s] = D_DestRob;
            end else begin
                busy_d = busy_d;
            end
        end
    end

    // Control state and issue bus: synchronous active-low reset, hold while !rdy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q     <= {RS_SIZE{1'b0}};
            rj_q       <= {RS_SIZE{1'b0}};
            rk_q       <= {RS_SIZE{1'b0}};
            rs_valid_q <= 1'b0;
            rs_op_q    <= OP_NOP;
            rs_vj_q    <= 32'd0;
            rs_vk_q    <= 32'd0;
            rs_imm_q   <= 32'd0;
            rs_pc_q    <= 32'd0;
            rs_dest_q  <= {ROB_LOG{1'b0}};
        end else if (rdy) begin
            busy_q     <= busy_d;
            rj_q       <= rj_d;
            rk_q       <= rk_d;
            rs_valid_q <= rs_valid_d;
            rs_op_q    <= rs_op_d;
            rs_vj_q    <= rs_vj_d;
            rs_vk_q    <= rs_vk_d;
            rs_imm_q   <= rs_imm_d;
            rs_pc_q    <= rs_pc_d;
            rs_dest_q  <= rs_dest_d;
        end
    end

    // Entry payload; meaningful only while the matching busy bit is set.
    always_ff @(posedge clk) begin
        if (rdy) begin
            op_q   <= op_d;
            vj_q   <= vj_d;
            vk_q   <= vk_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            qj_q   <= qj_d;
            qk_q   <= qk_d;
            dest_q <= dest_d;
        end
    end

    assign RS_valid   = rs_valid_q;
    assign RS_op      = rs_op_q;
    assign RS_Vj      = rs_vj_q;
    assign RS_Vk      = rs_vk_q;
    assign RS_Imm     = rs_imm_q;
    assign RS_DestRob = rs_dest_q;
    assign RS_CurPC   = rs_pc_q;

endmodule
